// File: rtl/arcade_input_pkg.sv
// Shared constants, types and the tank tread decode for the vector-game
// input front end.
package arcade_input_pkg;

  localparam logic [7:0] MOD_BATTLEZONE = 8'd0;
  localparam logic [7:0] MOD_BRADLEY    = 8'd1;
  localparam logic [7:0] MOD_REDBARON   = 8'd2;
  localparam logic [7:0] MOD_NONE       = 8'hFF;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  localparam logic [7:0] ANALOG_CENTER = 8'h80;

  typedef enum logic [1:0] {
    DIR_CENTER,
    DIR_POS,
    DIR_NEG
  } ramp_dir_t;

  // Left/right tread forward/back commands.
  typedef struct packed {
    logic wf;
    logic wb;
    logic xf;
    logic xb;
  } tank_cmd_t;

  // udlr = {Up, Down, Left, Right}; diagonals that make no tread sense map to idle.
  function automatic tank_cmd_t tank_decode(input logic [3:0] udlr);
    tank_cmd_t cmd;
    case (udlr)
      4'b1010: cmd = 4'b0010;
      4'b1000: cmd = 4'b1010;
      4'b1001: cmd = 4'b1000;
      4'b0001: cmd = 4'b1001;
      4'b0101: cmd = 4'b0100;
      4'b0100: cmd = 4'b0101;
      4'b0110: cmd = 4'b0001;
      4'b0010: cmd = 4'b0110;
      default: cmd = 4'b0000;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// ioctl download bus from hps_io into the input mapper.
interface arcade_input_mapper_if;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/analog_ramp_axis.sv
// One emulated analog axis: ramps while a direction is held, saturates at the
// rails and drifts back to centre when released or when both are held.
module analog_ramp_axis
  import arcade_input_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       tick,
  input  logic       pos,
  input  logic       neg,
  output logic [7:0] value
);

  ramp_dir_t dir;

  always_comb begin
    dir = DIR_CENTER;
    if (pos && !neg)      dir = DIR_POS;
    else if (neg && !pos) dir = DIR_NEG;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      value <= ANALOG_CENTER;
    end else if (tick) begin
      case (dir)
        DIR_POS: if (value != 8'hFF) value <= value + 8'd1;
        DIR_NEG: if (value != 8'h00) value <= value - 8'd1;
        default: begin
          if (value > ANALOG_CENTER)      value <= value - 8'd1;
          else if (value < ANALOG_CENTER) value <= value + 8'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Control-input front end for the Battlezone/Bradley/Red Baron cores:
// config capture, joystick merge, tank decode, coin stretch and analog select.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_DSW           = 8,
  parameter int MOD_INDEX         = 1,
  parameter int DSW_INDEX         = 254,
  parameter int COIN_PULSE_CYCLES = 500000,
  parameter int RAMP_DIV          = 4096
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  arcade_input_mapper_if.slave      ioctl,
  input  logic [16*NUM_PLAYERS-1:0] joy,
  input  logic [16*NUM_PLAYERS-1:0] joya,
  input  logic                      analog_mode,
  input  logic                      audiosel,
  output logic [7:0]                mod,
  output logic [8*NUM_DSW-1:0]      dsw,
  output logic [7:0]                jb,
  output logic [7:0]                arcade_buttons,
  output logic [7:0]                redbaron_buttons
);

  localparam int DSW_AW = (NUM_DSW > 1) ? $clog2(NUM_DSW) : 1;
  localparam int CW     = $clog2(COIN_PULSE_CYCLES);
  localparam int PW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  // NOTE: mod/dsw have power-up values but no reset, since the core sits in
  // reset for the whole download and would otherwise lose what it just received.
  logic [7:0]              mod_r = MOD_NONE;
  logic [NUM_DSW-1:0][7:0] dsw_r = '0;

  always_ff @(posedge clk_sys) begin
    if (ioctl.ioctl_wr) begin
      if (ioctl.ioctl_index == 8'(MOD_INDEX) && ioctl.ioctl_addr == '0)
        mod_r <= ioctl.ioctl_dout;
      if (ioctl.ioctl_index == 8'(DSW_INDEX) && ioctl.ioctl_addr < 25'(NUM_DSW))
        dsw_r[ioctl.ioctl_addr[DSW_AW-1:0]] <= ioctl.ioctl_dout;
    end
  end

  assign mod = mod_r;
  assign dsw = dsw_r;

  logic [7:0]  joy_or;
  logic [7:0]  joy_hi_unused;
  logic [15:0] ja_or;

  // NOTE: every always_comb output gets a default before the loop/branches so
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    joy_or        = '0;
    joy_hi_unused = '0;
    ja_or         = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_or        |= joy[16*p +: 8];
      joy_hi_unused |= joy[16*p+8 +: 8];
      ja_or         |= joya[16*p +: 16] ^ 16'h8080;
    end
  end

  logic           unused_ok;
  assign unused_ok = ^joy_hi_unused;

  logic [6:0]    j_r;
  logic [15:0]   ja_r;
  tank_cmd_t     tank_r;
  logic          coin_q;
  logic          coin_s;
  logic [CW-1:0] coin_cnt;
  logic [PW-1:0] pre_cnt;
  logic          ramp_tick;

  assign ramp_tick = (pre_cnt == PW'(RAMP_DIV - 1));

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      j_r      <= '0;
      ja_r     <= '0;
      tank_r   <= '0;
      coin_q   <= joy_or[JOY_COIN];  // a coin held across reset release is not an edge
      coin_s   <= 1'b0;
      coin_cnt <= '0;
      pre_cnt  <= '0;
    end else begin
      j_r     <= joy_or[6:0];
      ja_r    <= ja_or;
      tank_r  <= tank_decode(joy_or[3:0]);
      coin_q  <= joy_or[JOY_COIN];
      pre_cnt <= ramp_tick ? '0 : pre_cnt + 1'b1;
      if (coin_s) begin
        if (coin_cnt == '0) coin_s   <= 1'b0;
        else                coin_cnt <= coin_cnt - 1'b1;
      end else if (joy_or[JOY_COIN] && !coin_q) begin
        coin_s   <= 1'b1;
        coin_cnt <= CW'(COIN_PULSE_CYCLES - 1);
      end
    end
  end

  logic [7:0] ax, ay, aval;

  analog_ramp_axis u_ramp_x (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (ramp_tick),
    .pos     (j_r[JOY_RIGHT]),
    .neg     (j_r[JOY_LEFT]),
    .value   (ax)
  );

  analog_ramp_axis u_ramp_y (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tick    (ramp_tick),
    .pos     (j_r[JOY_UP]),
    .neg     (j_r[JOY_DOWN]),
    .value   (ay)
  );

  assign aval = analog_mode ? (audiosel ? ax : ay)
                            : (audiosel ? ja_r[7:0] : ja_r[15:8]);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      jb               <= '0;
      arcade_buttons   <= '0;
      redbaron_buttons <= '0;
    end else if (mod_r == MOD_REDBARON) begin
      jb <= {~coin_s, j_r[JOY_START1], j_r[JOY_START2], j_r[JOY_FIRE],
             j_r[JOY_DOWN], j_r[JOY_UP], j_r[JOY_RIGHT], j_r[JOY_LEFT]};
      arcade_buttons   <= aval;
      redbaron_buttons <= {j_r[JOY_FIRE], j_r[JOY_START1], 6'b0};
    end else begin
      jb <= {coin_s, j_r[JOY_START1], j_r[JOY_START2], j_r[JOY_FIRE], tank_r};
      arcade_buttons   <= {2'b00, j_r[JOY_START1], j_r[JOY_FIRE] | j_r[JOY_START2], tank_r};
      redbaron_buttons <= '0;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: config capture, tank decode, coin
// stretch, analog select and ramp, and reset behaviour.
module tb_arcade_input_mapper;
  import arcade_input_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [31:0] joy, joya;
  logic        analog_mode, audiosel;
  logic [7:0]  mod, jb, arcade_buttons, redbaron_buttons;
  logic [63:0] dsw;

  int checks   = 0;
  int failures = 0;
  int hi, lo, rises;
  logic prev;

  arcade_input_mapper_if ioctl_bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS       (2),
    .NUM_DSW           (8),
    .MOD_INDEX         (1),
    .DSW_INDEX         (254),
    .COIN_PULSE_CYCLES (10),
    .RAMP_DIV          (1)
  ) dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .ioctl            (ioctl_bus),
    .joy              (joy),
    .joya             (joya),
    .analog_mode      (analog_mode),
    .audiosel         (audiosel),
    .mod              (mod),
    .dsw              (dsw),
    .jb               (jb),
    .arcade_buttons   (arcade_buttons),
    .redbaron_buttons (redbaron_buttons)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_bus.ioctl_index = idx;
    ioctl_bus.ioctl_addr  = addr;
    ioctl_bus.ioctl_dout  = data;
    ioctl_bus.ioctl_wr    = 1'b1;
    tick(1);
    ioctl_bus.ioctl_wr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    joy = '0;
    joya = '0;
    analog_mode = 1'b0;
    audiosel = 1'b0;
    ioctl_bus.ioctl_wr = 1'b0;
    ioctl_bus.ioctl_index = '0;
    ioctl_bus.ioctl_addr = '0;
    ioctl_bus.ioctl_dout = '0;

    // Reset state and power-up config
    tick(1);
    check("rst_jb", jb, 8'h00);
    check("rst_arcade", arcade_buttons, 8'h00);
    check("rst_redbaron", redbaron_buttons, 8'h00);
    check("powerup_mod", mod, MOD_NONE);

    // Download while held in reset
    ioctl_write(8'd1, 25'd0, MOD_REDBARON);
    ioctl_write(8'd1, 25'd1, 8'd0);
    check("mod_addr0_only", mod, 8'h02);
    for (int a = 0; a < 9; a++) ioctl_write(8'd254, 25'(a), 8'(11 + a));
    check("dsw_capture", dsw, 64'h1211100F0E0D0C0B);
    ioctl_write(8'd3, 25'd0, 8'h55);
    check("mod_other_index", mod, 8'h02);

    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check("mod_after_reset", mod, 8'h02);
    check("dsw_after_reset", dsw, 64'h1211100F0E0D0C0B);

    // Tank decode, mod 0
    ioctl_write(8'd1, 25'd0, MOD_BATTLEZONE);
    joy = 32'h0000_0008;
    tick(2);
    check("tank_up_jb", jb, 8'h0A);
    check("tank_up_arcade", arcade_buttons, 8'h0A);
    check("tank_up_redbaron", redbaron_buttons, 8'h00);
    joy = 32'h0000_000A;
    tick(2);
    check("tank_up_left", jb, 8'h02);
    joy = 32'h0000_000C;
    tick(2);
    check("tank_up_down", jb, 8'h00);
    ioctl_write(8'd1, 25'd0, MOD_BRADLEY);
    joy = 32'h0030_0001;  // P1 Right, P2 fire+start1
    tick(2);
    check("tank_merge_jb", jb, 8'h59);
    check("tank_merge_arcade", arcade_buttons, 8'h39);

    // Coin stretcher: held coin gives one 10-cycle pulse
    joy = '0;
    tick(3);
    joy = 32'h0000_0080;
    hi = 0; rises = 0; prev = jb[7];
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (jb[7]) hi++;
      if (jb[7] && !prev) rises++;
      prev = jb[7];
    end
    check("coin_held_high", hi, 10);
    check("coin_held_pulses", rises, 1);

    // Re-press during a pulse does not extend it
    joy = '0;
    tick(5);
    hi = 0; rises = 0; prev = jb[7];
    for (int i = 0; i < 25; i++) begin
      joy = (i < 3 || (i >= 5 && i < 7)) ? 32'h0000_0080 : 32'h0;
      tick(1);
      if (jb[7]) hi++;
      if (jb[7] && !prev) rises++;
      prev = jb[7];
    end
    check("coin_repress_high", hi, 10);
    check("coin_repress_pulses", rises, 1);

    // Release then press again gives a fresh pulse
    hi = 0; rises = 0; prev = jb[7];
    for (int i = 0; i < 20; i++) begin
      joy = (i < 2) ? 32'h0000_0080 : 32'h0;
      tick(1);
      if (jb[7]) hi++;
      if (jb[7] && !prev) rises++;
      prev = jb[7];
    end
    check("coin_second_high", hi, 10);
    check("coin_second_pulses", rises, 1);

    // Red Baron, real analog stick (P2 at -128 contributes nothing)
    ioctl_write(8'd1, 25'd0, MOD_REDBARON);
    joya = 32'h8080_7F81;
    audiosel = 1'b1;
    tick(2);
    check("rb_x_analog", arcade_buttons, 8'h01);
    check("rb_idle_jb", jb, 8'h80);
    audiosel = 1'b0;
    tick(1);
    check("rb_y_analog", arcade_buttons, 8'hFF);
    joy = 32'h0000_0005;
    tick(2);
    check("rb_dir_jb", jb, 8'h8A);
    joy = 32'h0000_0010;
    tick(2);
    check("rb_fire_jb", jb, 8'h90);
    check("rb_fire_buttons", redbaron_buttons, 8'h80);

    // Ramp emulation
    joy = '0;
    tick(300);
    analog_mode = 1'b1;
    audiosel = 1'b1;
    tick(2);
    check("ramp_center", arcade_buttons, 8'h80);
    joy = 32'h0000_0001;
    tick(200);
    check("ramp_sat_ff", arcade_buttons, 8'hFF);
    tick(20);
    check("ramp_sat_hold", arcade_buttons, 8'hFF);
    audiosel = 1'b0;
    tick(1);
    check("ramp_y_idle", arcade_buttons, 8'h80);
    audiosel = 1'b1;
    tick(1);
    joy = '0;
    tick(128);
    check("ramp_return_126", arcade_buttons, 8'h81);
    tick(1);
    check("ramp_return_127", arcade_buttons, 8'h80);
    tick(10);
    check("ramp_center_hold", arcade_buttons, 8'h80);
    joy = 32'h0000_0002;
    tick(300);
    check("ramp_sat_00", arcade_buttons, 8'h00);

    // Reset during an active coin pulse and ramp
    joy = 32'h0000_0082;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midrst_jb", jb, 8'h00);
    check("midrst_arcade", arcade_buttons, 8'h00);
    check("midrst_redbaron", redbaron_buttons, 8'h00);
    tick(2);
    joy = 32'h0000_0080;
    reset = 1'b0;
    tick(1);
    check("postrst_ax_center", arcade_buttons, 8'h80);
    check("postrst_jb", jb, 8'h80);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!jb[7]) lo++;
    end
    check("held_coin_no_pulse", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
